// File: rtl/sprite_mem_loader_pkg.sv
// Shared sprite geometry constants used by the pattern-memory loader and its unpacker.
package sprite_mem_loader_pkg;

  localparam int SPRITE_DIM      = 16;
  localparam int SPRITE_PIX_BITS = 2;
  localparam int SPRITE_ADDR_W   = 8;
  localparam int SPRITE_SEL_W    = 6;
  localparam int PIX_PER_BYTE    = 4;
  localparam int BYTE_W          = SPRITE_PIX_BITS * PIX_PER_BYTE;

endpackage

// File: rtl/sprite_byte_unpacker.sv
// Holds one stream byte and emits its four 2-bit pixels LSB pair first, flagging the last one.
module sprite_byte_unpacker
  import sprite_mem_loader_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load,
  input  logic [BYTE_W-1:0]          in_byte,
  input  logic                       step,
  output logic [SPRITE_PIX_BITS-1:0] pix,
  output logic                       last
);

  logic [BYTE_W-1:0] shift_r;
  logic [1:0]        idx_r;

  // Shift register and pixel index: load a fresh byte, or advance one pixel per step.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_r <= {BYTE_W{1'b0}};
      idx_r   <= 2'd0;
    end else if (load) begin
      shift_r <= in_byte;
      idx_r   <= 2'd0;
    end else if (step) begin
      shift_r <= {{SPRITE_PIX_BITS{1'b0}}, shift_r[BYTE_W-1:SPRITE_PIX_BITS]};
      idx_r   <= idx_r + 2'd1;
    end
  end

  assign pix  = shift_r[SPRITE_PIX_BITS-1:0];
  assign last = (idx_r == 2'd3);

endmodule

// File: rtl/sprite_mem_loader.sv
// Streams a header byte plus 64 packed data bytes into the write port of a 16x16 sprite RAM.
module sprite_mem_loader
  import sprite_mem_loader_pkg::*;
#(
  parameter int NUM_SPRITES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       abort,
  output logic [SPRITE_SEL_W-1:0]    wr_select,
  output logic [SPRITE_ADDR_W-1:0]   wr_address,
  output logic [SPRITE_PIX_BITS-1:0] wr_data,
  output logic                       wr_en,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  typedef enum logic [1:0] {
    HDR    = 2'd0,
    DATA   = 2'd1,
    UNPACK = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                     state_r;
  logic                       in_ready_r;
  logic [SPRITE_SEL_W-1:0]    sel_r;
  logic [SPRITE_ADDR_W-1:0]   addr_r;
  logic                       wr_en_r;
  logic                       busy_r;
  logic                       done_r;
  logic                       err_r;

  logic                       xfer_s;
  logic                       hdr_ok_s;
  logic                       load_s;
  logic                       step_s;
  logic                       last_s;
  logic [SPRITE_PIX_BITS-1:0] pix_s;

  assign xfer_s   = in_valid & in_ready_r;
  // A full 8-bit compare also rejects any header with bits [7:6] set.
  assign hdr_ok_s = (in_data < 8'(NUM_SPRITES));
  assign load_s   = xfer_s & ~abort & (state_r == DATA);
  assign step_s   = ~abort & (state_r == UNPACK);

  sprite_byte_unpacker u_unpacker (
    .clock   (clock),
    .reset   (reset),
    .load    (load_s),
    .in_byte (in_data),
    .step    (step_s),
    .pix     (pix_s),
    .last    (last_s)
  );

  // Load FSM; every output register holds the value for the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= HDR;
      in_ready_r <= 1'b0;
      sel_r      <= {SPRITE_SEL_W{1'b0}};
      addr_r     <= {SPRITE_ADDR_W{1'b0}};
      wr_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else if (abort) begin
      state_r    <= HDR;
      in_ready_r <= 1'b1;
      wr_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        HDR: begin
          in_ready_r <= 1'b1;
          if (xfer_s) begin
            if (hdr_ok_s) begin
              sel_r   <= in_data[SPRITE_SEL_W-1:0];
              addr_r  <= {SPRITE_ADDR_W{1'b0}};
              busy_r  <= 1'b1;
              state_r <= DATA;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        DATA: begin
          if (xfer_s) begin
            in_ready_r <= 1'b0;
            wr_en_r    <= 1'b1;
            state_r    <= UNPACK;
          end
        end
        UNPACK: begin
          addr_r <= addr_r + 8'd1;
          if (last_s) begin
            wr_en_r <= 1'b0;
            if (addr_r == {SPRITE_ADDR_W{1'b1}}) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              in_ready_r <= 1'b1;
              state_r    <= DATA;
            end
          end
        end
        DONE: begin
          in_ready_r <= 1'b1;
          state_r    <= HDR;
        end
        default: begin
          in_ready_r <= 1'b1;
          wr_en_r    <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= HDR;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign wr_select  = sel_r;
  assign wr_address = addr_r;
  assign wr_data    = pix_s;
  assign wr_en      = wr_en_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: doc/sprite_mem_loader.md
Name: sprite_mem_loader

Overview:
- Write-side counterpart of the moving-sprite pattern memories. Consumes a byte stream from a host link, e.g. the UART receiver, over a valid/ready handshake.
- Unpacks each byte into four 2-bit pixels and drives the write port of the selected 16x16 sprite RAM: one pixel per clock, addresses {x,y} 0..255.
- Each byte carries 4 pixels; one load = 1 header byte + 64 data bytes.
- Lets sprite patterns be replaced at run time instead of only via mif init files.

Parameters:
- NUM_SPRITES, 2, number of sprite RAMs present. Valid header indices are 0..NUM_SPRITES-1, max 64.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  loader accepts in_data this cycle; a transfer occurs when in_valid & in_ready.
- abort  input  1  synchronous abandon of the current load.
- wr_select  output  6  target sprite index, held for the whole load.
- wr_address  output  8  pixel address {x[3:0], y[3:0]}; x in the high nibble.
- wr_data  output  2  pixel value.
- wr_en  output  1  write strobe, one pixel per cycle.
- busy  output  1  a load is in progress (header accepted, done not yet issued).
- done  output  1  one-cycle pulse after pixel 255 is written.
- err  output  1  one-cycle pulse on a rejected header.

Behaviour:
- Reset values: in_ready=0, wr_en=0, wr_select=0, wr_address=0, wr_data=0, busy=0, done=0, err=0. State=HDR.
- in_ready first rises the cycle after reset deasserts.
- States: HDR, DATA, UNPACK, DONE.
- HDR
  - in_ready=1.
  - On transfer with in_data < NUM_SPRITES: latch wr_select=in_data[5:0], clear pixel counter to 0, go to DATA.
  - On transfer with in_data >= NUM_SPRITES (this includes any byte with bits [7:6] != 0): pulse err the next cycle, stay in HDR, wr_select unchanged.
- DATA
  - in_ready=1, busy=1.
  - On transfer: latch the byte into the shift register, go to UNPACK.
  - No timeout; the loader waits indefinitely.
- UNPACK
  - in_ready=0, busy=1.
  - Four consecutive cycles with wr_en=1. On write k (k=0..3): wr_data = byte[2k+1:2k], LSB pair first; wr_address = pixel counter.
  - Counter increments after each write, 8-bit wrap.
  - After the 4th write: if the counter wrapped to 0 (256 pixels written), go to DONE; otherwise go to DATA.
- DONE
  - One cycle: done=1, busy=0, in_ready=0, then HDR.
  - A second load may start immediately; there is no inter-load gap requirement beyond this cycle.
- Registered outputs: wr_* change on the clock edge, valid in the same cycle wr_en is high. The RAM write lands on the following edge.
- Throughput: 1 data byte per 5 cycles minimum (1 accept cycle + 4 write cycles). A full load is at least 1 + 64*5 + 1 = 322 cycles.
- Pixel order: byte n holds pixels 4n..4n+3, i.e. x = n[5:2], y = {n[1:0], 2'b00}+k.
- abort: from any state, next cycle goes to HDR with wr_en=0 and busy=0. No done, no err. Pixels already written are not rolled back.
  - abort asserted in the same cycle as a transfer: abort wins and the byte is consumed and discarded.
- reset mid-load: same effect as abort, plus all registers return to their reset values.
- in_valid is ignored while in_ready=0. The source must hold data until accepted.

Decomposition:
- Shared sprite package holds: SPRITE_DIM=16, SPRITE_PIX_BITS=2, SPRITE_ADDR_W=8, SPRITE_SEL_W=6, PIX_PER_BYTE=4.
- The state encoding is local to this module.
- One natural sub-module: sprite_byte_unpacker, the shift register plus 2-bit pixel counter that emits 4 pixels and a last flag. The FSM and address counter stay in the top module.

Test Plan:
- Header 0x01, then 64 bytes 0x1B -> 256 writes on wr_select=1. Each byte yields wr_data 3,2,1,0 at consecutive addresses. done pulses once after address 0xFF is written. busy falls with done.
- Header 0x05 (NUM_SPRITES=2) -> err pulse 1 cycle, no wr_en, in_ready stays 1. A following 0x00 starts a normal load.
- Header 0x00, bytes with in_valid toggled randomly -> address sequence strictly 0..255 with no gaps or duplicates. in_ready=0 during every 4-cycle UNPACK window.
- Header 0x00, 10 data bytes, then abort -> wr_en=0 the next cycle, state HDR, no done. A new full load to sprite 1 then completes correctly starting at address 0.
- Reset asserted during UNPACK of byte 30 -> all outputs at reset values the next cycle. in_ready=1 one cycle after reset releases.
- Two back-to-back full loads (sprites 0 then 1), in_valid held high -> second header accepted the cycle after done. Total 644 cycles. Bench RAM model contents match the sent patterns.
